// File: rtl/uart_pro_pkg.sv
// Shared constants for the UART protocol response path: type codes, ASCII bytes, frame lengths.
// Frame-length helpers follow the address/data widths and the UART_PRO_TX_CHECKSUM_EN macro.
// No logic here, so there is no latency or backpressure.
package uart_pro_pkg;

    localparam logic [1:0] RSP_READ = 2'b00;
    localparam logic [1:0] RSP_WACK = 2'b01;
    localparam logic [1:0] RSP_ERR  = 2'b10;

    localparam logic [7:0] CH_SP = 8'h20;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_D  = 8'h44;
    localparam logic [7:0] CH_K  = 8'h4B;
    localparam logic [7:0] CH_E  = 8'h45;

`ifdef UART_PRO_TX_CHECKSUM_EN
    localparam int CK_LEN = 2;
`else
    localparam int CK_LEN = 0;
`endif

    // Error frame: letter, optional checksum, CR, LF.
    localparam int ER_LEN = 1 + CK_LEN + 2;

    typedef enum logic {ST_IDLE, ST_SEND} tx_state_t;

    // Read frame: letter, SP, address digits, SP, data digits, optional checksum, CR, LF.
    function automatic int rd_len(input int aw, input int dw);
        return 2 + aw / 4 + 1 + dw / 4 + CK_LEN + 2;
    endfunction

    // Write-ack frame: letter, SP, address digits, optional checksum, CR, LF.
    function automatic int wk_len(input int aw);
        return 2 + aw / 4 + CK_LEN + 2;
    endfunction

    // Leading letter of a frame; code 11 is reported as an error.
    function automatic logic [7:0] type_letter(input logic [1:0] t);
        case (t)
            RSP_READ: return CH_D;
            RSP_WACK: return CH_K;
            default:  return CH_E;
        endcase
    endfunction

endpackage

// File: rtl/uart_pro_hex_enc.sv
// Nibble to uppercase ASCII hex digit.
// Purely combinational, zero latency.
// No handshake; the output follows the input.
module uart_pro_hex_enc (
    input  logic [3:0] nib,
    output logic [7:0] asc
);

    // 0-9 map onto '0'..'9', 10-15 map onto 'A'..'F'.
    assign asc = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});

endmodule

// File: rtl/uart_pro_tx.sv
// Serialises one read/write-ack/error result into an ASCII frame, one byte per TX handshake.
// Latency: byte 0 valid the cycle after acceptance; one byte per cycle while TX_READY is high.
// Backpressure: TX_DATA holds while TX_READY is low; RSP_READY is low for the whole frame.
// Optional macro UART_PRO_TX_CHECKSUM_EN appends an XOR checksum as two hex digits before CR LF.
module uart_pro_tx
    import uart_pro_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              RSP_VALID,
    output logic              RSP_READY,
    input  logic [1:0]        RSP_TYPE,
    input  logic [ADDR_W-1:0] RSP_ADDR,
    input  logic [DATA_W-1:0] RSP_DATA,
    output logic              TX_VALID,
    input  logic              TX_READY,
    output logic [7:0]        TX_DATA,
    output logic              BUSY
);

    localparam int AD     = ADDR_W / 4;
    localparam int DD     = DATA_W / 4;
    localparam int RD_LEN = rd_len(ADDR_W, DATA_W);
    localparam int IDX_W  = $clog2(RD_LEN + 1);

    localparam logic [IDX_W-1:0] RD_LEN_I   = IDX_W'(RD_LEN);
    localparam logic [IDX_W-1:0] WK_LEN_I   = IDX_W'(wk_len(ADDR_W));
    localparam logic [IDX_W-1:0] ER_LEN_I   = IDX_W'(ER_LEN);
    localparam logic [IDX_W-1:0] ADDR_TOP_I = IDX_W'(AD + 1);       // index of last address digit
    localparam logic [IDX_W-1:0] ADDR_END_I = IDX_W'(AD + 2);       // SP between address and data
    localparam logic [IDX_W-1:0] DATA_TOP_I = IDX_W'(AD + DD + 2);  // index of last data digit

    tx_state_t         state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_n, cur_len;
    logic [1:0]        cap_type_q;
    logic [ADDR_W-1:0] cap_addr_q, addr_sh;
    logic [DATA_W-1:0] cap_data_q, data_sh;
    logic [7:0]        tx_data_q, lit, hex_chr, nxt_byte;
    logic [3:0]        nib;
    logic              hex_sel, accept, xfer, last;

`ifdef UART_PRO_TX_CHECKSUM_EN
    logic [7:0]        ck_q, ck_nxt;
    assign ck_nxt = ck_q ^ tx_data_q;
`endif

    assign RSP_READY = (state_q == ST_IDLE);
    assign TX_VALID  = (state_q == ST_SEND);
    assign BUSY      = (state_q == ST_SEND);
    assign TX_DATA   = tx_data_q;

    assign accept = RSP_VALID && RSP_READY;
    assign xfer   = TX_VALID && TX_READY;
    assign idx_n  = idx_q + IDX_W'(1);
    assign last   = (idx_q == cur_len - IDX_W'(1));

    // Frame length depends only on the captured response type.
    always_comb begin
        case (cap_type_q)
            RSP_READ: cur_len = RD_LEN_I;
            RSP_WACK: cur_len = WK_LEN_I;
            default:  cur_len = ER_LEN_I;
        endcase
    end

    // Next-state logic: accept in IDLE, leave SEND once the last byte is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (RSP_VALID) state_d = ST_SEND;
            ST_SEND: if (TX_READY && last) state_d = ST_IDLE;
        endcase
    end

    // Byte at idx_n: the tail is matched first so shorter frames never reach the digit fields.
    always_comb begin
        lit     = CH_SP;
        hex_sel = 1'b0;
        nib     = 4'h0;
        addr_sh = '0;
        data_sh = '0;
        if (idx_n == cur_len - IDX_W'(1)) begin
            lit = CH_LF;
        end else if (idx_n == cur_len - IDX_W'(2)) begin
            lit = CH_CR;
`ifdef UART_PRO_TX_CHECKSUM_EN
        end else if (idx_n == cur_len - IDX_W'(4)) begin
            // High digit: include the byte being transferred right now.
            hex_sel = 1'b1;
            nib     = ck_nxt[7:4];
        end else if (idx_n == cur_len - IDX_W'(3)) begin
            hex_sel = 1'b1;
            nib     = ck_q[3:0];
`endif
        end else if (idx_n == IDX_W'(1)) begin
            lit = CH_SP;
        end else if (idx_n <= ADDR_TOP_I) begin
            hex_sel = 1'b1;
            addr_sh = cap_addr_q >> {ADDR_TOP_I - idx_n, 2'b00};
            nib     = addr_sh[3:0];
        end else if (idx_n == ADDR_END_I) begin
            lit = CH_SP;
        end else begin
            hex_sel = 1'b1;
            data_sh = cap_data_q >> {DATA_TOP_I - idx_n, 2'b00};
            nib     = data_sh[3:0];
        end
    end

    uart_pro_hex_enc u_hex (
        .nib (nib),
        .asc (hex_chr)
    );

    assign nxt_byte = hex_sel ? hex_chr : lit;

    // State, capture registers, byte index and the registered output byte.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            cap_type_q <= '0;
            cap_addr_q <= '0;
            cap_data_q <= '0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cap_type_q <= RSP_TYPE;
                cap_addr_q <= RSP_ADDR;
                cap_data_q <= RSP_DATA;
                idx_q      <= '0;
                tx_data_q  <= type_letter(RSP_TYPE);
            end else if (xfer && !last) begin
                idx_q     <= idx_n;
                tx_data_q <= nxt_byte;
            end
        end
    end

`ifdef UART_PRO_TX_CHECKSUM_EN
    // XOR of every byte before the checksum digits; frozen once the digits start going out.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ck_q <= 8'h00;
        end else if (accept) begin
            ck_q <= 8'h00;
        end else if (xfer && (idx_q < cur_len - IDX_W'(4))) begin
            ck_q <= ck_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_uart_pro_tx.sv
// Directed bench for uart_pro_tx: table of response frames, backpressure, busy rejection and reset abort.
// Expected frames are hand-written ASCII strings; the checksum variant is selected by the same macro.
// Outputs are sampled on the falling edge, inputs are driven there too.
module tb_uart_pro_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_type;
    logic [7:0]  rsp_addr;
    logic [63:0] rsp_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_pro_tx #(.ADDR_W(8), .DATA_W(64)) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .RSP_VALID (rsp_valid),
        .RSP_READY (rsp_ready),
        .RSP_TYPE  (rsp_type),
        .RSP_ADDR  (rsp_addr),
        .RSP_DATA  (rsp_data),
        .TX_VALID  (tx_valid),
        .TX_READY  (tx_ready),
        .TX_DATA   (tx_data),
        .BUSY      (busy)
    );

    typedef struct {
        logic [1:0]   t;
        logic [7:0]   a;
        logic [63:0]  d;
        int           len;
        logic [199:0] exp;   // frame text, right-justified, first byte most significant
    } vec_t;

    vec_t vt[6];

`ifdef UART_PRO_TX_CHECKSUM_EN
    localparam int CKL = 2;
`else
    localparam int CKL = 0;
`endif

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int v, input int i);
        return vt[v].exp[(vt[v].len - 1 - i) * 8 +: 8];
    endfunction

    // Offer vector v, collect its frame with optional random backpressure, check the return to IDLE.
    task automatic run_vec(input int v, input bit bp);
        int   n;
        int   cyc;
        bit   held_vld;
        logic [7:0] held;
        logic tr;
        chk($sformatf("v%0d rsp_ready before", v), rsp_ready, 1);
        rsp_valid = 1'b1;
        rsp_type  = vt[v].t;
        rsp_addr  = vt[v].a;
        rsp_data  = vt[v].d;
        tx_ready  = 1'b0;
        @(negedge clk);
        rsp_valid = 1'b0;
        chk($sformatf("v%0d busy after accept", v), busy, 1);
        chk($sformatf("v%0d rsp_ready during send", v), rsp_ready, 0);
        n = 0;
        cyc = 0;
        held_vld = 1'b0;
        held = 8'h00;
        while (n < vt[v].len && cyc < 400) begin
            if (held_vld) chk($sformatf("v%0d hold byte %0d", v, n), tx_data, held);
            chk($sformatf("v%0d tx_valid byte %0d", v, n), tx_valid, 1);
            tr = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            tx_ready = tr;
            if (tr) begin
                chk($sformatf("v%0d byte %0d", v, n), tx_data, exp_byte(v, n));
                n++;
                held_vld = 1'b0;
            end else begin
                held = tx_data;
                held_vld = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        tx_ready = 1'b0;
        if (n < vt[v].len) begin
            errors++;
            $display("FAIL v%0d timeout: got %0d bytes, expected %0d", v, n, vt[v].len);
        end
        if (!bp) chk($sformatf("v%0d send cycles", v), cyc, vt[v].len);
        chk($sformatf("v%0d rsp_ready after", v), rsp_ready, 1);
        chk($sformatf("v%0d tx_valid gap", v), tx_valid, 0);
        chk($sformatf("v%0d busy after", v), busy, 0);
    endtask

    initial begin
        int n;
        vt[0] = '{2'b00, 8'h3A, 64'h0123456789ABCDEF, 23 + CKL, '0};
        vt[1] = '{2'b01, 8'h05, 64'h0,                6 + CKL,  '0};
        vt[2] = '{2'b11, 8'h00, 64'h0,                3 + CKL,  '0};
        vt[3] = '{2'b10, 8'h77, 64'hFFFF0000FFFF0000, 3 + CKL,  '0};
        vt[4] = '{2'b00, 8'hC0, 64'hFEDCBA9876543210, 23 + CKL, '0};
        vt[5] = '{2'b01, 8'hFF, 64'h1234,             6 + CKL,  '0};
`ifdef UART_PRO_TX_CHECKSUM_EN
        vt[0].exp = 200'({"D 3A 0123456789ABCDEF30", 8'h0D, 8'h0A});
        vt[1].exp = 200'({"K 056E", 8'h0D, 8'h0A});
        vt[2].exp = 200'({"E45", 8'h0D, 8'h0A});
        vt[3].exp = 200'({"E45", 8'h0D, 8'h0A});
        vt[4].exp = 200'({"D C0 FEDCBA987654321031", 8'h0D, 8'h0A});
        vt[5].exp = 200'({"K FF6B", 8'h0D, 8'h0A});
`else
        vt[0].exp = 200'({"D 3A 0123456789ABCDEF", 8'h0D, 8'h0A});
        vt[1].exp = 200'({"K 05", 8'h0D, 8'h0A});
        vt[2].exp = 200'({"E", 8'h0D, 8'h0A});
        vt[3].exp = 200'({"E", 8'h0D, 8'h0A});
        vt[4].exp = 200'({"D C0 FEDCBA9876543210", 8'h0D, 8'h0A});
        vt[5].exp = 200'({"K FF", 8'h0D, 8'h0A});
`endif

        rst_n     = 1'b0;
        rsp_valid = 1'b0;
        rsp_type  = 2'b00;
        rsp_addr  = 8'h00;
        rsp_data  = 64'h0;
        tx_ready  = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset rsp_ready", rsp_ready, 1);
        chk("reset tx_valid", tx_valid, 0);
        chk("reset tx_data", tx_data, 8'h00);
        chk("reset busy", busy, 0);
        rst_n = 1'b1;

        // TX_READY while idle must not start anything.
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle tx_ready tx_valid", tx_valid, 0);
        chk("idle tx_ready tx_data", tx_data, 8'h00);
        tx_ready = 1'b0;

        // Table vectors, back to back.
        for (int v = 0; v < 6; v++) run_vec(v, 1'b0);

        // Same read frame under random backpressure.
        run_vec(0, 1'b1);

        // Busy rejection then reset abort at byte 10.
        rsp_valid = 1'b1;
        rsp_type  = vt[0].t;
        rsp_addr  = vt[0].a;
        rsp_data  = vt[0].d;
        @(negedge clk);
        rsp_valid = 1'b0;
        tx_ready  = 1'b1;
        n = 0;
        while (n < 10) begin
            chk($sformatf("abort byte %0d", n), tx_data, exp_byte(0, n));
            if (n == 4) begin
                rsp_valid = 1'b1;
                rsp_type  = 2'b01;
                rsp_addr  = 8'h99;
                chk("busy pulse rsp_ready", rsp_ready, 0);
            end else begin
                rsp_valid = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        rsp_valid = 1'b0;
        chk("abort byte 10", tx_data, exp_byte(0, 10));
        tx_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort tx_valid", tx_valid, 0);
        chk("abort rsp_ready", rsp_ready, 1);
        chk("abort busy", busy, 0);
        chk("abort tx_data", tx_data, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post reset tx_valid", tx_valid, 0);
        run_vec(1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
